sqrt_seq: RTL and testbench

Parametrised sequential integer square-root unit for the sqrt_ASM core. It computes floor(sqrt(radicand)) and the remainder with the restoring digit-by-digit method, one result bit per clock. A generalised radicand/partial-remainder shift register feeds a small FSM. A start/busy/done handshake lets the femtoRV peripheral wrapper issue operations back to back.

---
 rtl/sqrt_pkg.sv | 21 ++
 rtl/sqrt_seq_if.sv | 31 +++
 rtl/sqrt_lsr.sv | 54 +++++
 rtl/sqrt_seq.sv | 122 ++++++++++++
 tb/tb_sqrt_seq.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types and constants for the sequential square-root unit
// Contents:
//   state_t    FSM state encoding (IDLE/RUN/DONE)
//   PAIR_W     radicand bits consumed per iteration
//   cnt_width  iteration counter width for a given radicand width
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PAIR_W = 2;

  // Counter must hold WIDTH/2 (the full iteration count) as well as 0.
  function automatic int cnt_width(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/sqrt_seq_if.sv
// rtl/sqrt_seq_if.sv - start/busy/done operand and result bundle for sqrt_seq
// Signals:
//   start      request, sampled while the unit is not busy
//   radicand   operand, captured on the accepting edge
//   busy       high while iterating
//   done       one-cycle result-valid pulse
//   root       floor(sqrt(radicand))
//   remainder  radicand - root^2
// Modports: master (issuer), slave (sqrt_seq).
interface sqrt_seq_if #(
  parameter int WIDTH = 16
);

  logic               start;
  logic [WIDTH-1:0]   radicand;
  logic               busy;
  logic               done;
  logic [WIDTH/2-1:0] root;
  logic [WIDTH/2:0]   remainder;

  modport master (
    output start, radicand,
    input  busy, done, root, remainder
  );

  modport slave (
    input  start, radicand,
    output busy, done, root, remainder
  );

endinterface

// File: rtl/sqrt_lsr.sv
// rtl/sqrt_lsr.sv - 2*WIDTH-bit radicand / partial-remainder shift register
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        upper half cleared, lower half <- load_data
//   load_data   pre-aligned radicand
//   shift       whole register shifts left by one bit pair, zero fill
//   lda2        parallel load of the upper half from lda2_data (zero-extended)
//   lda2_data   new partial remainder
//   rem         low WIDTH/2+1 bits of the upper half (partial-remainder field)
//   pair        next radicand bit pair to be consumed
module sqrt_lsr
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               shift,
  input  logic               lda2,
  input  logic [WIDTH/2+1:0] lda2_data,
  output logic [WIDTH/2:0]   rem,
  output logic [PAIR_W-1:0]  pair
);

  localparam int RW = WIDTH / 2 + 2;

  logic [2*WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0]   upper_load;

  always_comb begin
    upper_load          = '0;
    upper_load[RW-1:0]  = lda2_data;
    sr_d                = sr_q;
    if (load) begin
      sr_d = {{WIDTH{1'b0}}, load_data};
    end else begin
      if (shift) sr_d = sr_q << PAIR_W;
      // lda2 overrides the upper half while the lower half still shifts,
      // so one cycle both consumes a pair and stores the new remainder.
      if (lda2) sr_d[2*WIDTH-1:WIDTH] = upper_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign rem  = sr_q[WIDTH +: WIDTH/2+1];
  assign pair = sr_q[WIDTH-1 -: PAIR_W];

endmodule

// File: rtl/sqrt_seq.sv
// rtl/sqrt_seq.sv - sequential restoring integer square root, one root bit per clock
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sqrt_seq_if slave: start/radicand in, busy/done/root/remainder out
// Option: SQRT_EARLY_EXIT_EN skips leading all-zero radicand bit pairs.
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  sqrt_seq_if.slave  bus
);

  localparam int HALF = WIDTH / 2;
  localparam int RW   = HALF + 2;
  localparam int CW   = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [HALF-1:0]    root_q, root_d;

  logic               lsr_load, lsr_shift, lsr_lda2;
  logic [WIDTH-1:0]   load_data;
  logic [RW-1:0]      lda2_data;
  logic [HALF:0]      rem_field;
  logic [PAIR_W-1:0]  pair;
  logic [CW-1:0]      n_load;

  logic [RW-1:0]      rem_sh, trial;
  logic               ge;

`ifdef SQRT_EARLY_EXIT_EN
  logic [CW-1:0] lz;
  logic          found;

  // Count leading all-zero pairs from the top; stop at the first nonzero pair.
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = HALF - 1; i >= 0; i--) begin
      if (!found && bus.radicand[2*i +: 2] == 2'b00) lz = lz + CW'(1);
      else                                           found = 1'b1;
    end
  end

  assign n_load    = CW'(HALF) - lz;
  assign load_data = bus.radicand << {lz, 1'b0};
`else
  assign n_load    = CW'(HALF);
  assign load_data = bus.radicand;
`endif

  // Before the last iteration the remainder is below 2^HALF, so its low HALF
  // bits plus the incoming pair fit the RW-bit working width.
  always_comb begin
    rem_sh    = {rem_field[HALF-1:0], pair};
    trial     = {root_q, 2'b01};
    ge        = (rem_sh >= trial);
    lda2_data = ge ? (rem_sh - trial) : rem_sh;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    root_d    = root_q;
    lsr_load  = 1'b0;
    lsr_shift = 1'b0;
    lsr_lda2  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          lsr_load = 1'b1;
          root_d   = '0;
          cnt_d    = n_load;
          state_d  = (n_load == '0) ? DONE : RUN;
        end else if (state_q == DONE) begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        lsr_shift = 1'b1;
        lsr_lda2  = 1'b1;
        root_d    = {root_q[HALF-2:0], ge};
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      root_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
    end
  end

  sqrt_lsr #(.WIDTH(WIDTH)) u_lsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (lsr_load),
    .load_data (load_data),
    .shift     (lsr_shift),
    .lda2      (lsr_lda2),
    .lda2_data (lda2_data),
    .rem       (rem_field),
    .pair      (pair)
  );

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.root      = root_q;
  assign bus.remainder = rem_field;

endmodule

// File: tb/tb_sqrt_seq.sv
// tb/tb_sqrt_seq.sv - self-checking bench for sqrt_seq against an arithmetic reference
module tb_sqrt_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  sqrt_seq_if #(.WIDTH(W)) bus ();

  sqrt_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Cycles of iteration: all pairs, or only the significant pairs with early exit.
  function automatic int exp_iters(input int x);
`ifdef SQRT_EARLY_EXIT_EN
    int p = 0;
    while (p < W / 2 && (x >> (2 * p)) != 0) p++;
    return p;
`else
    return W / 2;
`endif
  endfunction

  // pre: start/radicand already driven by the previous call (back-to-back).
  // pulse_k: after sample k raise a start that the busy unit must ignore.
  // chain: leave start high with nxt during the DONE cycle.
  task automatic do_op(input int x, input bit pre, input int pulse_k,
                       input bit chain, input int nxt);
    int n, r, rm, dones;
    n  = exp_iters(x);
    r  = ref_root(x);
    rm = x - r * r;
    if (!pre) begin
      @(negedge clk);
      bus.start    = 1'b1;
      bus.radicand = 16'(x);
    end
    @(posedge clk);
    #1;
    dones = 0;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      bus.start    = 1'b0;
      bus.radicand = 16'($urandom);
      check_eq($sformatf("busy x=%0d k=%0d", x, k), 32'(bus.busy), 32'(k < n));
      check_eq($sformatf("done x=%0d k=%0d", x, k), 32'(bus.done), 32'(k == n));
      if (bus.done) dones++;
      if (k == pulse_k) begin
        bus.start    = 1'b1;
        bus.radicand = 16'(nxt);
      end
    end
    check_eq($sformatf("root x=%0d", x), 32'(bus.root), 32'(r));
    check_eq($sformatf("rem x=%0d", x), 32'(bus.remainder), 32'(rm));
    if (chain) begin
      bus.start    = 1'b1;
      bus.radicand = 16'(nxt);
    end else begin
      for (int j = 0; j < 3; j++) begin
        @(posedge clk);
        #1;
        if (bus.done) dones++;
        check_eq("busy idle", 32'(bus.busy), 32'd0);
      end
      check_eq($sformatf("done count x=%0d", x), 32'(dones), 32'd1);
      check_eq($sformatf("root hold x=%0d", x), 32'(bus.root), 32'(r));
      check_eq($sformatf("rem hold x=%0d", x), 32'(bus.remainder), 32'(rm));
    end
  endtask

  initial begin
    int seen_done;
    bus.start    = 1'b0;
    bus.radicand = '0;
    #1;
    check_eq("reset busy", 32'(bus.busy), 32'd0);
    check_eq("reset done", 32'(bus.done), 32'd0);
    check_eq("reset root", 32'(bus.root), 32'd0);
    check_eq("reset rem", 32'(bus.remainder), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(144, 1'b0, -1, 1'b0, 0);
    do_op(65535, 1'b0, -1, 1'b0, 0);
    do_op(2, 1'b0, -1, 1'b0, 0);
    do_op(0, 1'b0, -1, 1'b0, 0);
    do_op(3, 1'b0, -1, 1'b0, 0);
    do_op(1, 1'b0, -1, 1'b0, 0);
    do_op(4, 1'b0, -1, 1'b0, 0);

    // Start raised so that it is sampled at E4 while still iterating.
    do_op(144, 1'b0, 3, 1'b0, 65535);

    // Back to back: start held through the DONE cycle.
    do_op(144, 1'b0, -1, 1'b1, 50000);
    do_op(50000, 1'b1, -1, 1'b0, 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = 16'd65535;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", 32'(bus.busy), 32'd0);
    check_eq("abort done", 32'(bus.done), 32'd0);
    check_eq("abort root", 32'(bus.root), 32'd0);
    check_eq("abort rem", 32'(bus.remainder), 32'd0);
    seen_done = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
      if (j == 2) rst_n = 1'b1;
    end
    check_eq("abort no done", 32'(seen_done), 32'd0);
    do_op(144, 1'b0, -1, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      do_op(int'($urandom_range(0, 65535)), 1'b0, -1, 1'b0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      do_op(int'($urandom_range(0, 255)), 1'b0, -1, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
